// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB bridge constants and the slave front-end error FSM state type.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } err_state_t;

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational decode of NSLV equal windows of 2^WIN_LOG2 bytes starting at BASE.
module ahb_addr_decode #(
  parameter int                ADDR_W   = 32,
  parameter int                NSLV     = 3,
  parameter logic [ADDR_W-1:0] BASE     = 32'h8000_0000,
  parameter int                WIN_LOG2 = 26
) (
  input  logic [ADDR_W-1:0] haddr,
  output logic              mapped,
  output logic [NSLV-1:0]   tempselx
);

  logic              above_base_s;
  logic [ADDR_W-1:0] offset_s;
  logic [ADDR_W-1:0] win_idx_s;

  // Window index is taken from the offset, so the upper bound never needs BASE + size
  always_comb begin
    tempselx     = '0;
    above_base_s = (haddr >= BASE);
    offset_s     = haddr - BASE;
    win_idx_s    = offset_s >> WIN_LOG2;
    mapped       = above_base_s && (win_idx_s < ADDR_W'(NSLV));
    for (int i = 0; i < NSLV; i++) begin
      tempselx[i] = mapped && (win_idx_s == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/ahb_slave_if_gen.sv
// Generic AHB slave front end: window decode, two-stage address/data pipeline,
// two-cycle ERROR response for unmapped beats and a saturating error counter.
module ahb_slave_if_gen
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                NSLV     = 3,
  parameter logic [ADDR_W-1:0] BASE     = 32'h8000_0000,
  parameter int                WIN_LOG2 = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Hwrite,
  input  logic              Hreadyin,
  input  logic [1:0]        Htrans,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              bridge_ready,
  output logic              valid,
  output logic [ADDR_W-1:0] Haddr1,
  output logic [ADDR_W-1:0] Haddr2,
  output logic [DATA_W-1:0] Hwdata1,
  output logic [DATA_W-1:0] Hwdata2,
  output logic              Hwritereg,
  output logic [NSLV-1:0]   tempselx,
  output logic [DATA_W-1:0] Hrdata,
  output logic [1:0]        Hresp,
  output logic              Hreadyout,
  output logic [7:0]        err_cnt
);

  logic              mapped_s;
  logic [NSLV-1:0]   sel_s;
  logic              active_s;

  logic [ADDR_W-1:0] haddr1_d, haddr1_q, haddr2_d, haddr2_q;
  logic [DATA_W-1:0] hwdata1_d, hwdata1_q, hwdata2_d, hwdata2_q;
  logic              hwritereg_d, hwritereg_q;
  logic [7:0]        err_cnt_d, err_cnt_q;
  err_state_t        state_d, state_q;

  ahb_addr_decode #(
    .ADDR_W  (ADDR_W),
    .NSLV    (NSLV),
    .BASE    (BASE),
    .WIN_LOG2(WIN_LOG2)
  ) u_decode (
    .haddr   (Haddr),
    .mapped  (mapped_s),
    .tempselx(sel_s)
  );

  assign active_s = Hreadyin && ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ));
  assign Hrdata   = Prdata;

  // Pipeline stages advance only on bus-level ready
  always_comb begin
    haddr1_d    = haddr1_q;
    haddr2_d    = haddr2_q;
    hwdata1_d   = hwdata1_q;
    hwdata2_d   = hwdata2_q;
    hwritereg_d = hwritereg_q;
    if (Hreadyin) begin
      haddr1_d    = Haddr;
      haddr2_d    = haddr1_q;
      hwdata1_d   = Hwdata;
      hwdata2_d   = hwdata1_q;
      hwritereg_d = Hwrite;
    end else begin
      haddr1_d    = haddr1_q;
      haddr2_d    = haddr2_q;
      hwdata1_d   = hwdata1_q;
      hwdata2_d   = hwdata2_q;
      hwritereg_d = hwritereg_q;
    end
  end

  // Error FSM next state and error counter; beats during ERR1/ERR2 are not decoded
  always_comb begin
    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (active_s && !mapped_s) begin
          state_d = ST_ERR1;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            err_cnt_d = err_cnt_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Response and decode outputs; reset forces an idle OKAY view of the bus
  always_comb begin
    Hresp     = HRESP_OKAY;
    Hreadyout = bridge_ready;
    valid     = 1'b0;
    tempselx  = '0;
    if (!rst) begin
      Hresp     = HRESP_OKAY;
      Hreadyout = bridge_ready;
    end else begin
      tempselx = sel_s;
      valid    = active_s && mapped_s && (state_q == ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          Hresp     = HRESP_OKAY;
          Hreadyout = bridge_ready;
        end
        ST_ERR1: begin
          Hresp     = HRESP_ERROR;
          Hreadyout = 1'b0;
        end
        ST_ERR2: begin
          Hresp     = HRESP_ERROR;
          Hreadyout = 1'b1;
        end
        default: begin
          Hresp     = HRESP_OKAY;
          Hreadyout = bridge_ready;
        end
      endcase
    end
  end

  // State, pipeline and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      haddr1_q    <= '0;
      haddr2_q    <= '0;
      hwdata1_q   <= '0;
      hwdata2_q   <= '0;
      hwritereg_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      haddr1_q    <= haddr1_d;
      haddr2_q    <= haddr2_d;
      hwdata1_q   <= hwdata1_d;
      hwdata2_q   <= hwdata2_d;
      hwritereg_q <= hwritereg_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign Haddr1    = haddr1_q;
  assign Haddr2    = haddr2_q;
  assign Hwdata1   = hwdata1_q;
  assign Hwdata2   = hwdata2_q;
  assign Hwritereg = hwritereg_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/ahb_slave_if_gen.md
# ahb_slave_if_gen

Parametrised AHB slave front end for the AHB-to-APB bridge. It replaces the fixed 32-bit, three-peripheral front end with a generic one. It decodes NSLV equal-sized peripheral windows above a base address. It pipelines address, write data and control into two stages that advance only on accepted AHB beats, and returns a two-cycle AHB ERROR response for unmapped transfers. It sits between the AHB master and the bridge APB FSM, which consumes `valid`, the pipelined address/data and `tempselx`.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NSLV, 3, number of APB peripherals (1..8)
- BASE, 32'h8000_0000, base of peripheral space (aligned to 2^WIN_LOG2)
- WIN_LOG2, 26, log2 of per-peripheral window size in bytes
- clk  in  1  bus clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- Hwrite  in  1  AHB write control
- Hreadyin  in  1  AHB HREADY (bus-level ready)
- Htrans  in  2  AHB transfer type
- Haddr  in  ADDR_W  AHB address
- Hwdata  in  DATA_W  AHB write data
- Prdata  in  DATA_W  APB read data
- bridge_ready  in  1  APB FSM ready; low inserts wait states
- valid  out  1  accepted mapped NONSEQ/SEQ beat this cycle (combinational)
- Haddr1, Haddr2  out  ADDR_W  address pipeline stages 1 and 2
- Hwdata1, Hwdata2  out  DATA_W  write-data pipeline stages 1 and 2
- Hwritereg  out  1  registered Hwrite
- tempselx  out  NSLV  one-hot peripheral select (combinational)
- Hrdata  out  DATA_W  equal to Prdata
- Hresp  out  2  00 OKAY, 01 ERROR
- Hreadyout  out  1  slave HREADYOUT
- err_cnt  out  8  saturating count of ERROR responses

## Operation
- `mapped` = BASE ≤ Haddr < BASE + (NSLV << WIN_LOG2). Compute the comparison without overflow at ADDR_W bits.
- `active` = Hreadyin && Htrans ∈ {10 NONSEQ, 11 SEQ}. IDLE (00) and BUSY (01) are never active and always get OKAY.
- `valid` = rst && active && mapped && state==IDLE.
- `tempselx`:
  - When rst and mapped, bit ((Haddr−BASE) >> WIN_LOG2) is set.
  - Otherwise all zeros.
  - Independent of Htrans, matching the existing bridge contract.
- Pipeline, when Hreadyin=1:
  - Haddr1←Haddr, Haddr2←Haddr1, Hwdata1←Hwdata, Hwdata2←Hwdata1, Hwritereg←Hwrite.
  - When Hreadyin=0, all five registers hold.
- Error FSM states: IDLE, ERR1, ERR2.
  - IDLE→ERR1 when active && !mapped.
  - ERR1→ERR2 unconditionally.
  - ERR2→IDLE unconditionally.
- Outputs per FSM state:
  - IDLE: Hresp=00, Hreadyout=bridge_ready.
  - ERR1: Hresp=01, Hreadyout=0.
  - ERR2: Hresp=01, Hreadyout=1.
- err_cnt increments by 1 on entry to ERR1 and saturates at 255.
- Hrdata = Prdata, with no register.

## Timing
- Reset (rst=0 at a clock edge) clears:
  - all pipeline registers, Hwritereg and err_cnt to 0;
  - the FSM to IDLE.
- While rst=0, the combinational outputs are valid=0, tempselx=0, Hresp=00, Hreadyout=bridge_ready.
- Reset mid-error: FSM returns to IDLE at that edge, and ERROR is not completed.
- Latencies:
  - Address accepted in cycle N appears on Haddr1 in cycle N+1 and on Haddr2 in cycle N+2.
  - Write data presented in cycle N+1 appears on Hwdata1 in N+2.
- `valid` has zero latency, in the address-phase cycle.
- An unmapped beat in cycle N gives:
  - Hresp=01, Hreadyout=0 in N+1;
  - Hresp=01, Hreadyout=1 in N+2;
  - a new beat may be accepted in N+3.
- A beat presented during ERR1/ERR2 is not decoded; `valid` is forced 0.
- bridge_ready is ignored in ERR1/ERR2.
- err_cnt updates at the edge ending cycle N and is visible in N+1.

## Structure
- Shared package `ahb_apb_pkg` holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HRESP_OKAY/ERROR;
  - the error FSM state enum `err_state_t`.
- Sub-module `ahb_addr_decode` (parameters ADDR_W, NSLV, BASE, WIN_LOG2) is purely combinational and produces `mapped` and one-hot `tempselx`.
- The pipeline, FSM and counter live in the top.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with Htrans=10, Haddr=8000_0000. Require valid=0, tempselx=000, all registers 0, Hresp=00, err_cnt=0.
- **Decode:** with defaults, Htrans=10, Hreadyin=1, Haddr = 8000_0000, 8400_0004, 8BFF_FFFC. Require tempselx = 001, 010, 100 respectively, valid=1 each cycle, and Haddr2 equal to each address two cycles later.
- **Stall:** accept 8000_0010, then drop Hreadyin for 3 cycles. Require Haddr1 to hold 8000_0010 and Haddr2 to hold its prior value; with Hreadyin=0, valid=0.
- **Error:** Htrans=10 at Haddr=8C00_0000. Require:
  - Hresp=01/Hreadyout=0 in the next cycle;
  - 01/1 in the cycle after;
  - then 00, with err_cnt=1.
  - A NONSEQ to 8000_0000 presented during ERR1 gives valid=0.
- **BUSY/IDLE and wait:** Htrans=01 at a mapped address gives valid=0 and Hresp=00. With bridge_ready=0 in IDLE, Hreadyout=0.
- **Saturation and parametrisation:** 260 unmapped beats give err_cnt=255. Rerun the decode test with NSLV=5, WIN_LOG2=12, BASE=4000_0000: address 4000_4000 gives tempselx=10000, and 4000_5000 gives an ERROR response.
